// File: rtl/ps2_pkg.sv
// Shared constants and FSM state types for the PS/2 keyboard front end.
// PS2_PARITY_CHECK_EN (optional) enables odd-parity enforcement in ps2_frame_rx.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_NONE   = 8'h00;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_NORM,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_t;

  // True when data plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deserialiser: synchroniser, clock glitch filter, frame FSM, timeout.
// Build option PS2_PARITY_CHECK_EN: parity mismatch drops the byte and pulses frame_err.
//
// state     | meaning
// ----------+----------------------------------------------
// FR_IDLE   | waiting for a start bit (data=0 on a falling edge)
// FR_DATA   | shifting in 8 data bits, LSB first
// FR_PARITY | sampling the parity bit
// FR_STOP   | sampling the stop bit, byte accepted or rejected
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic          filt;
  logic          filt_d;
  logic [FW-1:0] filt_cnt;
  logic          sample_evt;

  frame_state_t  state;
  frame_state_t  state_n;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          shift_en;
  logic          valid_set;
  logic          err_set;
  logic          par_ok;

  // Lines idle high, so the synchronisers and filter reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // filt_cnt counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign sample_evt = filt_d & ~filt;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if (sample_evt && state == FR_PARITY) begin
      par_bit <= data_s;
    end
  end

  assign par_ok = odd_parity_ok(shreg, par_bit);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FR_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_en  = 1'b0;
    valid_set = 1'b0;
    err_set   = 1'b0;
    case (state)
      FR_IDLE: begin
        if (sample_evt) begin
          if (!data_s) state_n = FR_DATA;
          else         err_set = 1'b1;
        end
      end
      FR_DATA: begin
        if (sample_evt) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_n = FR_PARITY;
        end
      end
      FR_PARITY: begin
        if (sample_evt) state_n = FR_STOP;
      end
      FR_STOP: begin
        if (sample_evt) begin
          state_n = FR_IDLE;
          if (data_s && par_ok) valid_set = 1'b1;
          else                  err_set   = 1'b1;
        end
      end
      default: state_n = FR_IDLE;
    endcase
    // A sample event in the same cycle keeps the frame alive.
    if (state != FR_IDLE && !sample_evt && to_cnt == '0) begin
      state_n   = FR_IDLE;
      shift_en  = 1'b0;
      valid_set = 1'b0;
      err_set   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= TO_LOAD;
      rx_byte   <= PS2_NONE;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= valid_set;
      frame_err <= err_set;
      if (valid_set) rx_byte <= shreg;
      if (state == FR_IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (sample_evt || state == FR_IDLE) begin
        to_cnt <= TO_LOAD;
      end else if (to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard front end: receives frames and tracks the two most recently held make codes.
// Build option PS2_PARITY_CHECK_EN is passed through to ps2_frame_rx.
//
// state       | meaning
// ------------+-------------------------------------------
// DEC_NORM    | next byte is a make code or a prefix
// DEC_BRK     | F0 seen, next byte is a released key
// DEC_EXT     | E0 seen, extended key follows
// DEC_EXT_BRK | E0 F0 seen, extended release follows
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan,
  output logic [7:0] prevscan,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  import ps2_pkg::*;

  dec_state_t dstate;
  dec_state_t dstate_n;
  logic [7:0] scan_n;
  logic [7:0] prevscan_n;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dstate   <= DEC_NORM;
      scan     <= PS2_NONE;
      prevscan <= PS2_NONE;
    end else begin
      dstate   <= dstate_n;
      scan     <= scan_n;
      prevscan <= prevscan_n;
    end
  end

  always_comb begin
    dstate_n   = dstate;
    scan_n     = scan;
    prevscan_n = prevscan;
    if (rx_valid) begin
      case (dstate)
        DEC_NORM: begin
          if (rx_byte == PS2_BREAK) begin
            dstate_n = DEC_BRK;
          end else if (rx_byte == PS2_EXT) begin
            dstate_n = DEC_EXT;
          end else if (rx_byte != scan) begin
            // New make and re-press of prevscan both shift the old scan down.
            scan_n     = rx_byte;
            prevscan_n = scan;
          end
        end
        DEC_BRK: begin
          dstate_n = DEC_NORM;
          if (rx_byte == scan) begin
            scan_n     = prevscan;
            prevscan_n = PS2_NONE;
          end else if (rx_byte == prevscan) begin
            prevscan_n = PS2_NONE;
          end
        end
        DEC_EXT: begin
          dstate_n = (rx_byte == PS2_BREAK) ? DEC_EXT_BRK : DEC_NORM;
        end
        DEC_EXT_BRK: begin
          dstate_n = DEC_NORM;
        end
        default: dstate_n = DEC_NORM;
      endcase
    end
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
PS/2 keyboard front end. It deserialises PS/2 device-to-host frames and decodes make, break and extended sequences. It presents the held key as `scan` and the previously pressed, still-held key as `prevscan`, e.g. Shift 0x12 plus a note key. It sits directly upstream of the note/sound controller, which consumes `scan` and `prevscan`.

Parameters:
- FILTER_LEN, 8: clk cycles `ps2_clk` must be stable before an edge is accepted.
- TIMEOUT_CYC, 200000: clk cycles with no accepted falling edge mid-frame before the frame is aborted (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- ps2_clk  in  1  raw PS/2 clock line, asynchronous
- ps2_data  in  1  raw PS/2 data line, asynchronous
- scan  out  8  make code of the most recently pressed, still-held key; 0x00 = none
- prevscan  out  8  make code of the key pressed before `scan`, still held; 0x00 = none
- rx_byte  out  8  last correctly received raw byte
- rx_valid  out  1  one-cycle pulse when rx_byte updates
- frame_err  out  1  one-cycle pulse on parity, start or stop error, or timeout

Behaviour:
- Reset: scan=0x00, prevscan=0x00, rx_byte=0x00, rx_valid=0, frame_err=0, both FSMs idle, extended/break flags cleared, filter counter 0.
- Input conditioning:
  - 2-flop synchroniser on each line.
  - `ps2_clk` glitch filter: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock is a "sample event"; `ps2_data` (synchronised) is sampled on it.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: sample event with data=0 → DATA, bit count=0. Sample event with data=1 → stay in IDLE, pulse frame_err.
  - DATA: shift in LSB first; after the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: data=1 and odd parity OK → rx_byte<=byte, rx_valid=1 in the cycle after the stop-bit sample event. Otherwise pulse frame_err, no rx_valid. Either way → IDLE.
  - Timeout: in DATA, PARITY or STOP, a counter reaching TIMEOUT_CYC with no sample event → IDLE, frame_err pulse, partial byte discarded. The counter clears on every sample event.
- Decode FSM, states NORM, BRK, EXT, EXT_BRK; acts on rx_valid only:
  - NORM: 0xF0 → BRK. 0xE0 → EXT. Any other byte X is a make:
    - X==scan (typematic repeat): no change.
    - X==prevscan: swap so scan=X and prevscan=old scan.
    - Otherwise: prevscan<=scan, scan<=X.
  - BRK: byte Y → NORM.
    - Y==scan: scan<=prevscan, prevscan<=0x00.
    - Y==prevscan: prevscan<=0x00.
    - Else: ignored.
  - EXT: 0xF0 → EXT_BRK. Any other byte → NORM, ignored. Extended keys never reach scan or prevscan.
  - EXT_BRK: any byte → NORM, ignored.
- Latency: scan/prevscan update in the cycle after the rx_valid pulse, i.e. 2 clk after the stop-bit sample event.
- Errors: a frame_err leaves the decode FSM state unchanged. A lost byte is resynchronised by the next valid frame.
- Reset mid-frame: the partial frame is dropped; no rx_valid or frame_err is issued for it.
- Simultaneous timeout and sample event: the sample event wins.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a parity mismatch drops the byte and pulses frame_err.
- Undefined: the parity bit is captured but ignored; only start, stop and timeout errors pulse frame_err.

Decomposition:
- Package `ps2_pkg` holds:
  - constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `PS2_NONE`=8'h00, `PS2_LSHIFT`=8'h12;
  - enums for the frame FSM and decode FSM states.
- Sub-module `ps2_frame_rx` holds the synchroniser, filter, frame FSM and timeout, and outputs rx_byte, rx_valid and frame_err.
- `ps2_scan_rx` instantiates it and implements the decode FSM.

Test Plan:
1. Frame 0x23 (bits 1,1,0,0,0,1,0,0, parity 0, stop 1) at 12 kHz PS/2 clock → rx_byte=0x23, one rx_valid; scan=0x23, prevscan=0x00.
2. Sequence 0x12, 0x23, F0 23, F0 12 → (scan,prevscan) steps through (12,00), (23,12), (12,00), (00,00).
3. Make 0x23 repeated five times (typematic) → scan stays 0x23, prevscan stays 0x00.
4. Frame 0x23 with parity bit 1:
   - with PS2_PARITY_CHECK_EN → frame_err pulse, scan unchanged;
   - without it → scan=0x23.
5. Stop sending after 4 data bits for more than TIMEOUT_CYC cycles, then send a full 0x2D frame → one frame_err pulse, then scan=0x2D.
6. Sequences:
   - E0 75 → scan unchanged.
   - E0 F0 75 → scan unchanged.
   - 3-cycle glitch on ps2_clk mid-frame → no extra bit; the next byte decodes correctly.
   - reset asserted mid-frame → all outputs 0x00/0; the next frame decodes correctly.
